// File: rtl/bp_coh_link_concentrator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_coh_link_concentrator: N-to-1 wormhole link concentrator (packet-locked RR mux + channel-ID demux)
// Rev 1.0
// ----------------------------------------------------------------------------
module bp_coh_link_concentrator #(
  parameter  int flit_width_p  = 16,
  parameter  int len_width_p   = 4,
  parameter  int len_pos_p     = 0,
  parameter  int els_p         = 2,
  parameter  int chan_pos_p    = len_pos_p + len_width_p,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [els_p-1:0][link_width_lp-1:0]   tile_link_i,
  output logic [els_p-1:0][link_width_lp-1:0]   tile_link_o,
  input  logic [link_width_lp-1:0]              network_link_i,
  output logic [link_width_lp-1:0]              network_link_o,
  output logic                                  err_o
);

  localparam int             W     = flit_width_p;
  localparam int             CW    = ($clog2(els_p) > 0) ? $clog2(els_p) : 1;
  localparam logic [CW:0]    ELS_C = (CW+1)'(els_p);
  localparam logic [len_width_p-1:0] LEN_ONE = len_width_p'(1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  logic [els_p-1:0]         tile_v, tile_rdy;
  logic [els_p-1:0][W-1:0]  tile_data;

  for (genvar i = 0; i < els_p; i++) begin : g_unpack
    assign tile_v[i]    = tile_link_i[i][W+1];
    assign tile_rdy[i]  = tile_link_i[i][W];
    assign tile_data[i] = tile_link_i[i][W-1:0];
  end

  // ---------------- mux path ----------------
  state_e                 mstate_q;
  logic [CW-1:0]          gnt_q, rr_q;
  logic [len_width_p-1:0] cnt_q;
  logic [W-1:0]           fifo_mem_q [2];
  logic                   fifo_wptr_q, fifo_rptr_q;
  logic [1:0]             fifo_cnt_q;

  logic [CW-1:0]          win, win_inc, sel;
  logic                   win_found;
  logic [CW:0]            idx;
  logic                   fifo_full, can_acc, mux_acc, out_v, pop;
  logic [len_width_p-1:0] mux_len;

  // Round-robin search starting at rr_q, wrapping modulo els_p.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < els_p; k++) begin
      idx = {1'b0, rr_q} + (CW+1)'(k);
      if (idx >= ELS_C) idx = idx - ELS_C;
      if (!win_found && tile_v[idx[CW-1:0]]) begin
        win       = idx[CW-1:0];
        win_found = 1'b1;
      end
    end
    win_inc = ({1'b0, win} == ELS_C - 1'b1) ? '0 : win + 1'b1;
  end

  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign sel       = (mstate_q == S_BUSY) ? gnt_q : win;
  assign can_acc   = ((mstate_q == S_BUSY) || win_found) && !fifo_full && !reset_i;
  assign mux_acc   = can_acc && tile_v[sel];
  assign mux_len   = tile_data[sel][len_pos_p +: len_width_p];
  assign out_v     = (fifo_cnt_q != 2'd0);
  assign pop       = out_v && network_link_i[W];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mstate_q    <= S_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (mux_acc) begin
        fifo_mem_q[fifo_wptr_q] <= tile_data[sel];
        fifo_wptr_q             <= ~fifo_wptr_q;
      end
      if (pop) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, mux_acc} - {1'b0, pop};
      case (mstate_q)
        S_IDLE: if (mux_acc) begin
          rr_q <= win_inc;
          if (mux_len != '0) begin
            cnt_q    <= mux_len;
            gnt_q    <= win;
            mstate_q <= S_BUSY;
          end
        end
        S_BUSY: if (mux_acc) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LEN_ONE) mstate_q <= S_IDLE;
        end
        default: mstate_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- demux path ----------------
  state_e                 dstate_q;
  logic [CW-1:0]          dst_q;
  logic                   ill_q, err_q;
  logic [len_width_p-1:0] dcnt_q;

  logic                   net_v, dst_rdy, legal, dmx_rdy, dmx_acc;
  logic [W-1:0]           net_data;
  logic [CW-1:0]          hdr_chan, dst;
  logic [len_width_p-1:0] dmx_len;

  assign net_v    = network_link_i[W+1];
  assign net_data = network_link_i[W-1:0];
  assign hdr_chan = net_data[chan_pos_p +: CW];
  assign dmx_len  = net_data[len_pos_p +: len_width_p];
  assign dst      = (dstate_q == S_BUSY) ? dst_q : hdr_chan;
  assign legal    = (dstate_q == S_BUSY) ? !ill_q : ({1'b0, hdr_chan} < ELS_C);

  always_comb begin
    dst_rdy = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (dst == CW'(i)) dst_rdy = tile_rdy[i];
    end
  end

  // Illegal-ID packets are drained unconditionally so the network never blocks on them.
  assign dmx_rdy = !reset_i && (!legal || dst_rdy);
  assign dmx_acc = net_v && dmx_rdy;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dstate_q <= S_IDLE;
      dst_q    <= '0;
      ill_q    <= 1'b0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (dstate_q)
        S_IDLE: if (dmx_acc) begin
          if (!legal) err_q <= 1'b1;
          if (dmx_len != '0) begin
            dcnt_q   <= dmx_len;
            dst_q    <= hdr_chan;
            ill_q    <= !legal;
            dstate_q <= S_BUSY;
          end
        end
        S_BUSY: if (dmx_acc) begin
          dcnt_q <= dcnt_q - 1'b1;
          if (dcnt_q == LEN_ONE) dstate_q <= S_IDLE;
        end
        default: dstate_q <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_tile_out
    assign tile_link_o[i] = {net_v && legal && (dst == CW'(i)) && !reset_i,
                             can_acc && (sel == CW'(i)),
                             net_data};
  end

  assign network_link_o = {out_v, dmx_rdy, fifo_mem_q[fifo_rptr_q]};
  assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_coh_link_concentrator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bp_coh_link_concentrator: directed self-checking bench (els_p=5, len at [11:8], chan at [14:12])
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bp_coh_link_concentrator;

  localparam int E = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [E-1:0]      tv, trdy;
  logic [E-1:0][15:0] td;
  logic              nv, nrdy;
  logic [15:0]       nd;
  logic [E-1:0][17:0] tile_in, tile_out;
  logic [17:0]       net_in, net_out;
  logic              err;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  logic [15:0] outq [$];
  int          outc [$];
  logic [15:0] eq   [$];

  logic [15:0] pkt    [E][8];
  int          plen   [E];
  int          pstart [E];
  int          pidx   [E];
  int          acc_t  [E][8];
  int          acc_a  [E][8];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < E; i++) tile_in[i] = {tv[i], trdy[i], td[i]};
    net_in = {nv, nrdy, nd};
  end

  bp_coh_link_concentrator #(
    .flit_width_p(16), .len_width_p(4), .len_pos_p(8), .els_p(E), .chan_pos_p(12)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .tile_link_i(tile_in), .tile_link_o(tile_out),
    .network_link_i(net_in), .network_link_o(net_out),
    .err_o(err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && net_out[17] && nrdy) begin
      outq.push_back(net_out[15:0]);
      outc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [E-1:0] tvo();
    logic [E-1:0] r;
    for (int i = 0; i < E; i++) r[i] = tile_out[i][17];
    return r;
  endfunction

  function automatic logic [E-1:0] tro();
    logic [E-1:0] r;
    for (int i = 0; i < E; i++) r[i] = tile_out[i][16];
    return r;
  endfunction

  task automatic clear_src();
    for (int i = 0; i < E; i++) begin
      plen[i] = 0; pstart[i] = 0; pidx[i] = 0;
    end
  endtask

  // Drives each channel's packet as a valid-then-ready source; network ready held low for `stall` cycles.
  task automatic run_src(input int stall, input int max_c);
    bit done;
    bit acc [E];
    done = 1'b0;
    for (int c = 0; c < max_c && !done; c++) begin
      for (int ch = 0; ch < E; ch++) begin
        if (c >= pstart[ch] && pidx[ch] < plen[ch]) begin
          tv[ch] = 1'b1; td[ch] = pkt[ch][pidx[ch]];
        end else begin
          tv[ch] = 1'b0; td[ch] = '0;
        end
      end
      nrdy = (c >= stall);
      #1;
      for (int ch = 0; ch < E; ch++) begin
        acc[ch] = tv[ch] && tile_out[ch][16];
        if (acc[ch]) begin
          acc_t[ch][pidx[ch]] = c;
          acc_a[ch][pidx[ch]] = cyc;
        end
      end
      tick();
      done = 1'b1;
      for (int ch = 0; ch < E; ch++) begin
        if (acc[ch]) pidx[ch]++;
        if (pidx[ch] < plen[ch]) done = 1'b0;
      end
    end
    tv = '0;
    nrdy = 1'b1;
    chk("run_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_out(input string tag, input bit contig);
    chk({tag, "_count"}, outq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < outq.size(); i++) begin
      chk({tag, "_data"}, {16'd0, outq[i]}, {16'd0, eq[i]});
      if (contig && i > 0) chk({tag, "_gap"}, outc[i] - outc[i-1], 1);
    end
    outq.delete();
    outc.delete();
  endtask

  initial begin
    rst = 1'b1; tv = '0; trdy = '1; td = '0; nv = 1'b0; nrdy = 1'b1; nd = '0;
    clear_src();
    tick(); tick();
    #1;
    chk("rst_net_v",   {31'd0, net_out[17]}, 32'd0);
    chk("rst_net_rdy", {31'd0, net_out[16]}, 32'd0);
    chk("rst_tile_rdy", {27'd0, tro()}, 32'd0);
    chk("rst_tile_v",   {27'd0, tvo()}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    // Single channel, len=3
    clear_src();
    plen[1] = 4;
    pkt[1][0] = 16'h03A0; pkt[1][1] = 16'h00A1; pkt[1][2] = 16'h00A2; pkt[1][3] = 16'h00A3;
    run_src(0, 20);
    repeat (3) tick();
    chk("t1_latency", (outc.size() > 0) ? outc[0] : -1, acc_a[1][0] + 1);
    chk("t1_contig_acc", acc_t[1][3], 3);
    eq = {16'h03A0, 16'h00A1, 16'h00A2, 16'h00A3};
    check_out("t1", 1'b1);

    // Four simultaneous len=1 headers from rr=0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    clear_src();
    for (int k = 0; k < 4; k++) begin
      plen[k] = 2;
      pkt[k][0] = 16'h0100 + 16'(k * 16);
      pkt[k][1] = 16'h0001 + 16'(k * 16);
    end
    run_src(0, 30);
    repeat (3) tick();
    chk("t2_ch0_hdr", acc_t[0][0], 0);
    chk("t2_ch1_hdr", acc_t[1][0], 2);
    chk("t2_ch3_tail", acc_t[3][1], 7);
    eq = {16'h0100, 16'h0001, 16'h0110, 16'h0011, 16'h0120, 16'h0021, 16'h0130, 16'h0031};
    check_out("t2", 1'b1);

    // Interleave attempt: ch2 must wait for ch0's tail
    clear_src();
    plen[0] = 6;
    pkt[0][0] = 16'h05D0;
    for (int k = 1; k < 6; k++) pkt[0][k] = 16'h00D0 + 16'(k);
    plen[2] = 2; pstart[2] = 1;
    pkt[2][0] = 16'h01E0; pkt[2][1] = 16'h00E1;
    run_src(0, 30);
    repeat (3) tick();
    chk("t3_ch0_tail", acc_t[0][5], 5);
    chk("t3_ch2_hdr", acc_t[2][0], 6);
    eq = {16'h05D0, 16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4, 16'h00D5, 16'h01E0, 16'h00E1};
    check_out("t3", 1'b1);

    // Back-pressure: network stalled 5 cycles during len=2 packet
    clear_src();
    plen[3] = 3;
    pkt[3][0] = 16'h02C0; pkt[3][1] = 16'h00C1; pkt[3][2] = 16'h00C2;
    run_src(5, 30);
    repeat (3) tick();
    chk("t4_body1", acc_t[3][1], 1);
    chk("t4_tail_after_release", acc_t[3][2], 6);
    eq = {16'h02C0, 16'h00C1, 16'h00C2};
    check_out("t4", 1'b1);

    // Demux: chan 2, len 2
    nv = 1'b1; nd = 16'h2200; #1;
    chk("t5_hdr_v", {27'd0, tvo()}, 32'b00100);
    chk("t5_hdr_data", {16'd0, tile_out[2][15:0]}, 32'h2200);
    chk("t5_hdr_rdy", {31'd0, net_out[16]}, 32'd1);
    tick();
    nd = 16'h0011; #1;
    chk("t5_body_v", {27'd0, tvo()}, 32'b00100);
    trdy[2] = 1'b0; #1;
    chk("t5_stall_rdy", {31'd0, net_out[16]}, 32'd0);
    tick();
    trdy[2] = 1'b1; #1;
    chk("t5_release_rdy", {31'd0, net_out[16]}, 32'd1);
    tick();
    nd = 16'h0012; #1;
    chk("t5_tail_v", {27'd0, tvo()}, 32'b00100);
    tick();
    nd = 16'h0000; #1;
    chk("t5_next_hdr_v", {27'd0, tvo()}, 32'b00001);
    tick();
    nv = 1'b0;

    // Illegal channel ID 5, len 1
    nv = 1'b1; nd = 16'h5100; #1;
    chk("t6_hdr_v", {27'd0, tvo()}, 32'd0);
    chk("t6_hdr_rdy", {31'd0, net_out[16]}, 32'd1);
    chk("t6_err_pre", {31'd0, err}, 32'd0);
    tick();
    chk("t6_err_set", {31'd0, err}, 32'd1);
    trdy[0] = 1'b0; nd = 16'h0020; #1;
    chk("t6_body_v", {27'd0, tvo()}, 32'd0);
    chk("t6_body_rdy", {31'd0, net_out[16]}, 32'd1);
    tick();
    trdy[0] = 1'b1; nv = 1'b0;
    tick();
    chk("t6_err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-packet on both paths
    nv = 1'b1; nd = 16'h1300;
    nrdy = 1'b0; tv[4] = 1'b1; td[4] = 16'h0340;
    tick();
    nd = 16'h0031; td[4] = 16'h0041;
    tick();
    rst = 1'b1; nv = 1'b0; tv = '0;
    tick();
    chk("t7_err_clr", {31'd0, err}, 32'd0);
    rst = 1'b0; nrdy = 1'b1;
    tick();
    chk("t7_no_emit", {31'd0, net_out[17]}, 32'd0);
    nv = 1'b1; nd = 16'h3000;
    tv[2] = 1'b1; td[2] = 16'h00F0; #1;
    chk("t7_demux_route", {27'd0, tvo()}, 32'b01000);
    chk("t7_mux_idle", {27'd0, tro()}, 32'b00100);
    tick();
    nv = 1'b0; tv = '0;
    repeat (3) tick();
    eq = {16'h00F0};
    check_out("t7", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_coh_link_concentrator.md
# bp_coh_link_concentrator

Parametrised N-to-1 wormhole link concentrator for the coherence network. It multiplexes `els_p` tile-side ready-and links onto one network link, with round-robin arbitration locked for a whole packet. It also demultiplexes the returning network link back to the tile links using a channel-ID field in the header flit. It sits between a tile's LCE/accelerator endpoints and a single socket port, replacing a fixed two-element socket bundle.

## Interface
Parameters:
- `flit_width_p`, `coh_noc_flit_width_p`: flit data width.
- `len_width_p`, `coh_noc_len_width_p`: width of the header length field (count of body flits after the header).
- `len_pos_p`, 0: LSB position of the length field in the header flit.
- `els_p`, 2: number of tile-side channels, 2..16.
- `chan_pos_p`, `len_pos_p+len_width_p`: LSB of the channel-ID field (`chan_width = max(1,$clog2(els_p))`) in the header.
- `link_width_lp` (localparam): `bsg_ready_and_link_sif_width(flit_width_p)`, packed as {v, ready_and, data}.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `tile_link_i` in `[els_p-1:0][link_width_lp]`: tile→concentrator flits, and ready_and for the return path.
- `tile_link_o` out `[els_p-1:0][link_width_lp]`: demuxed flits to the tiles, and ready_and for the mux inputs.
- `network_link_i` in `link_width_lp`: network→concentrator flits, and network ready_and.
- `network_link_o` out `link_width_lp`: muxed flits to the network, and ready_and for the network input.
- `err_o` out 1: sticky flag set when a header carries channel ID ≥ `els_p`; cleared only by reset.

## Operation
Mux path (tile→network):
- States are IDLE and BUSY, with a locked grant index `gnt_r` and a remaining-flit counter `cnt_r` (`len_width_p` bits).
- **IDLE:** round-robin over channels with v=1, starting at pointer `rr_r`. The winner's header is accepted when output buffer space exists.
  - On acceptance with len≠0, load `cnt_r`=len and go to BUSY.
  - With len=0, stay IDLE.
  - Either way, `rr_r` ← winner+1 mod `els_p`.
- **BUSY:** only `gnt_r` is ready. Each accepted flit decrements `cnt_r`. Acceptance at `cnt_r`=1 returns to IDLE. Other channels see ready_and=0.
- **Output buffer:** a 2-entry FIFO feeding `network_link_o`. Input ready_and = FIFO not full and channel selected. This is a valid-then-ready handshake; a flit transfers when v & ready_and.

Demux path (network→tile):
- States are IDLE and BUSY, with `dst_r` and `dcnt_r`.
- Header channel ID selects the destination. The flit passes combinationally to `tile_link_o[dst]`, and network ready_and = the destination tile's ready_and.
- Len≠0 locks `dst_r` and goes to BUSY until the body flits are consumed, exactly as on the mux path.
- **Illegal ID (≥`els_p`):** the whole packet is consumed with ready_and=1 and no tile v asserted, and `err_o` is set.

The two paths are fully independent and run concurrently.

## Timing
- **Reset values:** all v outputs 0; all ready_and outputs 0 during reset. Both FSMs IDLE; `rr_r`=0, `cnt_r`=`dcnt_r`=0; FIFO empty; `err_o`=0. These values take effect the cycle after `reset_i` is sampled high.
- **Reset mid-packet:** partial packet state is discarded; no flit is emitted after reset.
- **Mux latency:** a flit accepted at cycle t appears on `network_link_o` v at t+1.
- **Mux throughput:** 1 flit/cycle under continuous network ready. Back-to-back packets from different channels incur no bubble, because arbitration happens in the cycle after the tail flit is accepted.
- **Demux latency:** 0 cycles (combinational pass-through). There is no bubble between packets.
- **Simultaneous headers:** the lowest index at or above `rr_r` wins. The others hold v and data stable; ready_and=0 for them.
- **Network back-pressure:** with the FIFO full, all tile ready_and=0 and state is frozen.
- **Counters:** `cnt_r` never wraps; the maximum body length is 2^`len_width_p`−1.

## Test plan
- **Single channel, len=3:** channel 1 sends 4 flits (0xA0..0xA3) with continuous ready → `network_link_o` shows 0xA0..0xA3 on cycles t+1..t+4, no interleaving.
- **All 4 channels (els_p=4) raise a len=1 header on the same cycle, rr_r=0:** packets emerge in order ch0, ch1, ch2, ch3 as 8 contiguous flits; `rr_r` ends at 0.
- **Interleave attempt:** ch0 is mid-packet (len=5) and ch2 raises a header → ch2 ready_and stays 0 until the cycle after ch0's tail is accepted; ch0's flits are contiguous at the output.
- **Back-pressure:** network ready_and=0 for 5 cycles during a len=2 packet → at most 2 flits are buffered, no flit is lost or duplicated, and order is preserved after release.
- **Demux:** network header with channel ID=2, len=2 → 3 flits appear only on `tile_link_o[2]`. Deasserting tile 2 ready_and stalls the network ready_and.
- **Illegal ID and reset:** header channel ID=5 with els_p=4, len=1 → both flits are consumed, no tile v is asserted, and `err_o`=1. A subsequent `reset_i` pulse mid-packet → `err_o`=0, both FSMs IDLE, and the next header is routed normally.
